// File: rtl/regs_mul_seq_pkg.sv
// ---------------------------------------------------------------------------
// regs_mul_seq_pkg
// Shared constants for the sequential fixed-point multiplier that sits behind
// the register file read ports.
//   WIDTH_DEF     : datapath / register width (matches `REG_SIZE)
//   FRAC_BITS_DEF : fraction bits of the datapath fixed-point format
//   ADDR_W_DEF    : register address width (matches `REG_ADDR_SIZE)
//   UNITY         : fixed-point encoding of 1.0
//   ST_*          : FSM state encodings
// ---------------------------------------------------------------------------
package regs_mul_seq_pkg;

   localparam int WIDTH_DEF     = 8;
   localparam int FRAC_BITS_DEF = 3;
   localparam int ADDR_W_DEF    = 3;
   localparam int UNITY         = 1 << FRAC_BITS_DEF;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_BUSY   = 2'd1;
   localparam logic [1:0] ST_FINISH = 2'd2;

endpackage

// File: rtl/regs_mul_seq_if.sv
// ---------------------------------------------------------------------------
// regs_mul_seq_if
// Request / write-back bundle between the register file side and the
// multiplier.
//   master : drives start, a (q1), b (q2), dest; observes the write-back side
//   slave  : the multiplier; returns busy, done, we, wr_addr, result, ovf
// ---------------------------------------------------------------------------
interface regs_mul_seq_if #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 3
);
   logic              start;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic [ADDR_W-1:0] dest;
   logic              busy;
   logic              done;
   logic              we;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  result;
   logic              ovf;

   modport master (
      output start, a, b, dest,
      input  busy, done, we, wr_addr, result, ovf
   );

   modport slave (
      input  start, a, b, dest,
      output busy, done, we, wr_addr, result, ovf
   );
endinterface

// File: rtl/regs_mul_seq_fx_saturate.sv
// ---------------------------------------------------------------------------
// fx_saturate
// Combinational sign-apply and clamp of an unsigned fixed-point magnitude to a
// signed WIDTH-bit value.
//   mag  : unsigned magnitude, already shifted down to the output format
//   sign : 1 = result is negative
//   res  : signed, saturated result
//   ovf  : 1 = clamping took place
// Positive range tops out at 2^(WIDTH-1)-1, negative range at -2^(WIDTH-1),
// so a magnitude of exactly 2^(WIDTH-1) is only legal when negative.
// ---------------------------------------------------------------------------
module fx_saturate #(
   parameter int WIDTH = 8,
   parameter int MAG_W = 13
) (
   input  logic [MAG_W-1:0] mag,
   input  logic             sign,
   output logic [WIDTH-1:0] res,
   output logic             ovf
);

   localparam logic [MAG_W-1:0] POS_LIM = {{(MAG_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic [MAG_W-1:0] NEG_LIM = {{(MAG_W-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

   // Sign application with clamping at the format limits.
   always_comb begin
      res = {WIDTH{1'b0}};
      ovf = 1'b0;
      if (sign) begin
         if (mag > NEG_LIM) begin
            res = {1'b1, {(WIDTH-1){1'b0}}};
            ovf = 1'b1;
         end else begin
            // -(2^(WIDTH-1)) wraps to itself, which is the intended value.
            res = ~mag[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1};
            ovf = 1'b0;
         end
      end else begin
         if (mag > POS_LIM) begin
            res = {1'b0, {(WIDTH-1){1'b1}}};
            ovf = 1'b1;
         end else begin
            res = mag[WIDTH-1:0];
            ovf = 1'b0;
         end
      end
   end

endmodule

// File: rtl/regs_mul_seq.sv
// ---------------------------------------------------------------------------
// regs_mul_seq
// Multi-cycle signed fixed-point multiplier fed by the register file read
// ports; returns a saturated product for the register file write port.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : regs_mul_seq_if.slave
//           start/a/b/dest in; busy/done/we/wr_addr/result/ovf out
// Operands are converted to magnitudes at acceptance, multiplied with one
// shift-add step per cycle, then truncated toward zero and saturated.
// ---------------------------------------------------------------------------
module regs_mul_seq
   import regs_mul_seq_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int FRAC_BITS = FRAC_BITS_DEF,
   parameter int ADDR_W    = ADDR_W_DEF
) (
   input logic           clk,
   input logic           reset,
   regs_mul_seq_if.slave bus
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int ACC_W = 2 * WIDTH;
   localparam int MAG_W = ACC_W - FRAC_BITS;

   logic [1:0]        state_r;
   logic [WIDTH-1:0]  mcand_r;
   logic [WIDTH-1:0]  mplier_r;
   logic              sign_r;
   logic [ADDR_W-1:0] dest_r;
   logic [ACC_W-1:0]  acc_r;
   logic [CNT_W-1:0]  count_r;
   logic              busy_r;
   logic              done_r;
   logic [ADDR_W-1:0] wr_addr_r;
   logic [WIDTH-1:0]  result_r;
   logic              ovf_r;

   logic [ACC_W-1:0]  pp_s;
   logic [WIDTH-1:0]  sat_res_s;
   logic              sat_ovf_s;

   // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1).
   function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v);
      if (v[WIDTH-1]) begin
         return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         return v;
      end
   endfunction

   // Partial product for the current iteration.
   always_comb begin
      pp_s = {ACC_W{1'b0}};
      pp_s = {{WIDTH{1'b0}}, mcand_r} << count_r;
   end

   fx_saturate #(
      .WIDTH (WIDTH),
      .MAG_W (MAG_W)
   ) u_sat (
      .mag  (acc_r[ACC_W-1:FRAC_BITS]),
      .sign (sign_r),
      .res  (sat_res_s),
      .ovf  (sat_ovf_s)
   );

   // FSM, shift-add datapath and registered write-back outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         mcand_r   <= {WIDTH{1'b0}};
         mplier_r  <= {WIDTH{1'b0}};
         sign_r    <= 1'b0;
         dest_r    <= {ADDR_W{1'b0}};
         acc_r     <= {ACC_W{1'b0}};
         count_r   <= {CNT_W{1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         wr_addr_r <= {ADDR_W{1'b0}};
         result_r  <= {WIDTH{1'b0}};
         ovf_r     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  mcand_r  <= mag_of(bus.a);
                  mplier_r <= mag_of(bus.b);
                  sign_r   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                  dest_r   <= bus.dest;
                  acc_r    <= {ACC_W{1'b0}};
                  count_r  <= {CNT_W{1'b0}};
                  busy_r   <= 1'b1;
                  state_r  <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               done_r <= 1'b0;
               if (mplier_r[count_r]) begin
                  acc_r <= acc_r + pp_s;
               end
               count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
               if (count_r == CNT_W'(WIDTH - 1)) begin
                  state_r <= ST_FINISH;
               end
            end
            ST_FINISH: begin
               // Outputs land on this edge, so done/we appear in the
               // following IDLE cycle, where a new start may be accepted.
               result_r  <= sat_res_s;
               ovf_r     <= sat_ovf_s;
               wr_addr_r <= dest_r;
               done_r    <= 1'b1;
               busy_r    <= 1'b0;
               state_r   <= ST_IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
   assign bus.we      = done_r;
   assign bus.wr_addr = wr_addr_r;
   assign bus.result  = result_r;
   assign bus.ovf     = ovf_r;

endmodule
